bit4_serial_subtractor: RTL

- Bit-serial counterpart to the team's combinational 4-bit adder: computes D = A - B one bit per clock, LSB first, and reports the borrow out.
- Uses a start/busy/done handshake and a small FSM.
- Intended for area-constrained datapaths and as a cross-check partner in adder/subtractor benches: A + B from the adder, then subtracting B here, must return A.

---
 rtl/bit4_serial_subtractor_if.sv | 28 ++
 rtl/bit4_serial_subtractor.sv | 115 +++++++++++
 2 files changed

// File: rtl/bit4_serial_subtractor_if.sv
// Handshake/data bundle for the bit-serial subtractor.
//   start      : request, sampled only while the subtractor is idle
//   A, B       : minuend / subtrahend, captured on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle completion pulse
//   D, Bout    : registered difference and borrow out, held until next completion
// master = requester side, slave = subtractor side.
interface bit4_serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;

    modport master (
        output start, A, B,
        input  busy, done, D, Bout
    );

    modport slave (
        input  start, A, B,
        output busy, done, D, Bout
    );
endinterface

// File: rtl/bit4_serial_subtractor.sv
// Bit-serial subtractor: D = A - B (mod 2^WIDTH), one bit per clock, LSB
// first, with borrow out Bout = (A < B) unsigned.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears state and results
//   bus    : slave side of bit4_serial_subtractor_if (start/A/B in,
//            busy/done/D/Bout out)
// Timing: start accepted at edge 0, busy for WIDTH cycles, done pulse in
// cycle WIDTH+1, back in IDLE in cycle WIDTH+2.
module bit4_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bit4_serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    // Holds the WIDTH-1 difference bits already produced; the final bit is
    // concatenated on top when the result is committed to D.
    logic [WIDTH-2:0] r_sh_reg, r_sh_next;
    logic             br_reg, br_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic             bout_reg, bout_next;

    logic             d_bit;
    logic             br_bit;
    logic [WIDTH-1:0] r_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            r_sh_reg  <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            d_reg     <= '0;
            bout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            r_sh_reg  <= r_sh_next;
            br_reg    <= br_next;
            cnt_reg   <= cnt_next;
            d_reg     <= d_next;
            bout_reg  <= bout_next;
        end
    end

    always_comb begin
        // Full-subtractor cell for the current bit position.
        d_bit  = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
        br_bit = (~a_sh_reg[0] & b_sh_reg[0]) |
                 (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
        r_full = {d_bit, r_sh_reg};

        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        r_sh_next  = r_sh_reg;
        br_next    = br_reg;
        cnt_next   = cnt_reg;
        d_next     = d_reg;
        bout_next  = bout_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    a_sh_next  = bus.A;
                    b_sh_next  = bus.B;
                    r_sh_next  = '0;
                    br_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next = a_sh_reg >> 1;
                b_sh_next = b_sh_reg >> 1;
                r_sh_next = r_full[WIDTH-1:1];
                br_next   = br_bit;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    // Last bit: commit result and the final borrow.
                    d_next     = r_full;
                    bout_next  = br_bit;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);
    assign bus.D    = d_reg;
    assign bus.Bout = bout_reg;
endmodule
